// File: rtl/png_chunk_chk.sv
// PNG chunk checker: parses length/type/payload/CRC fields from a byte stream,
// forwards the payload and verifies the CRC-32 over type and payload bytes.
module png_chunk_chk #(
    parameter logic [31:0] MAX_LEN = 32'h7FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        val_i,
    input  logic [7:0]  dat_i,
    output logic        val_o,
    output logic [7:0]  dat_o,
    output logic        lst_o,
    output logic        hdr_val_o,
    output logic [31:0] len_o,
    output logic [31:0] typ_o,
    output logic        done_o,
    output logic        err_o,
    output logic        len_err_o,
    output logic [31:0] crc_o
);

    typedef enum logic [2:0] {IDLE, LEN, TYP, DAT, CRC} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [30:0] rem_q;
    logic [31:0] len_q;
    logic [31:0] typ_q;
    logic [31:0] rcrc_q;
    logic [31:0] crc_q;

    logic        val_q;
    logic [7:0]  dat_q;
    logic        lst_q;
    logic        hdr_val_q;
    logic [31:0] len_out_q;
    logic [31:0] typ_out_q;
    logic        done_q;
    logic        err_q;
    logic        len_err_q;
    logic [31:0] crc_out_q;

    logic [31:0] len_d;
    logic [31:0] typ_d;
    logic [31:0] rcrc_d;
    logic [31:0] crc_d;

    // Reflected CRC-32 update by one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Next values of the big-endian field shifters and the running CRC.
    always_comb begin
        len_d  = {len_q[23:0], dat_i};
        typ_d  = {typ_q[23:0], dat_i};
        rcrc_d = {rcrc_q[23:0], dat_i};
        crc_d  = crc_byte(crc_q, dat_i);
    end

    // Chunk parser FSM with registered outputs; start_i aborts any partial chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            rem_q     <= 31'd0;
            len_q     <= 32'd0;
            typ_q     <= 32'd0;
            rcrc_q    <= 32'd0;
            crc_q     <= 32'hFFFF_FFFF;
            val_q     <= 1'b0;
            dat_q     <= 8'd0;
            lst_q     <= 1'b0;
            hdr_val_q <= 1'b0;
            len_out_q <= 32'd0;
            typ_out_q <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
            crc_out_q <= 32'd0;
        end else begin
            val_q     <= 1'b0;
            lst_q     <= 1'b0;
            hdr_val_q <= 1'b0;
            done_q    <= 1'b0;
            if (start_i) begin
                state_q <= LEN;
                cnt_q   <= 2'd0;
                rem_q   <= 31'd0;
                len_q   <= 32'd0;
                typ_q   <= 32'd0;
                rcrc_q  <= 32'd0;
                crc_q   <= 32'hFFFF_FFFF;
            end else if (val_i) begin
                case (state_q)
                    IDLE: begin
                    end
                    LEN: begin
                        len_q <= len_d;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (len_d > MAX_LEN) begin
                                done_q    <= 1'b1;
                                len_err_q <= 1'b1;
                                err_q     <= 1'b0;
                                state_q   <= IDLE;
                            end else begin
                                rem_q   <= len_d[30:0];
                                crc_q   <= 32'hFFFF_FFFF;
                                state_q <= TYP;
                            end
                        end
                    end
                    TYP: begin
                        typ_q <= typ_d;
                        crc_q <= crc_d;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            hdr_val_q <= 1'b1;
                            len_out_q <= len_q;
                            typ_out_q <= typ_d;
                            state_q   <= (rem_q != 31'd0) ? DAT : CRC;
                        end
                    end
                    DAT: begin
                        val_q <= 1'b1;
                        dat_q <= dat_i;
                        crc_q <= crc_d;
                        rem_q <= rem_q - 31'd1;
                        if (rem_q == 31'd1) begin
                            lst_q   <= 1'b1;
                            state_q <= CRC;
                        end
                    end
                    CRC: begin
                        rcrc_q <= rcrc_d;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            done_q    <= 1'b1;
                            crc_out_q <= ~crc_q;
                            err_q     <= (~crc_q != rcrc_d);
                            len_err_q <= 1'b0;
                            crc_q     <= 32'hFFFF_FFFF;
                            state_q   <= LEN;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign val_o     = val_q;
    assign dat_o     = dat_q;
    assign lst_o     = lst_q;
    assign hdr_val_o = hdr_val_q;
    assign len_o     = len_out_q;
    assign typ_o     = typ_out_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign len_err_o = len_err_q;
    assign crc_o     = crc_out_q;

endmodule

// File: tb/tb_png_chunk_chk.sv
// Self-checking bench for png_chunk_chk: directed chunks plus random chunks,
// compared against a table-driven chunk parser model.
module tb_png_chunk_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        val_i;
    logic [7:0]  dat_i;
    logic        val_o;
    logic [7:0]  dat_o;
    logic        lst_o;
    logic        hdr_val_o;
    logic [31:0] len_o;
    logic [31:0] typ_o;
    logic        done_o;
    logic        err_o;
    logic        len_err_o;
    logic [31:0] crc_o;

    png_chunk_chk dut (
        .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
        .val_o(val_o), .dat_o(dat_o), .lst_o(lst_o), .hdr_val_o(hdr_val_o),
        .len_o(len_o), .typ_o(typ_o), .done_o(done_o), .err_o(err_o),
        .len_err_o(len_err_o), .crc_o(crc_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  stream[$];
    logic [9:0]  act_pay[$], exp_pay[$];
    logic [63:0] act_hdr[$], exp_hdr[$];
    logic [33:0] act_done[$], exp_done[$];
    logic [31:0] tbl[256];

    // Observed events, sampled on the falling edge.
    always @(negedge clk) begin
        if (val_o || lst_o) act_pay.push_back({val_o, lst_o, dat_o});
        if (hdr_val_o) act_hdr.push_back({len_o, typ_o});
        if (done_o) act_done.push_back({err_o, len_err_o, crc_o});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_tab(input logic [31:0] c, input logic [7:0] b);
        return tbl[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    task automatic add(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    task automatic add_iend(input logic [31:0] rc);
        add(32'h0);
        add(32'h4945_4E44);
        add(rc);
    endtask

    // Parse the byte stream the way a PNG reader would and list expected events.
    task automatic model();
        int p;
        logic [31:0] len, typ, rc, crc;
        p = 0;
        while (p + 4 <= stream.size()) begin
            len = {stream[p], stream[p+1], stream[p+2], stream[p+3]};
            p += 4;
            if (len > 32'h7FFF_FFFF) begin
                exp_done.push_back({2'b01, 32'h0});
                return;
            end
            if (p + 4 > stream.size()) return;
            typ = {stream[p], stream[p+1], stream[p+2], stream[p+3]};
            crc = 32'hFFFF_FFFF;
            for (int k = 0; k < 4; k++) crc = crc_tab(crc, stream[p+k]);
            p += 4;
            exp_hdr.push_back({len, typ});
            for (int i = 0; i < int'(len); i++) begin
                if (p >= stream.size()) return;
                exp_pay.push_back({1'b1, (i == int'(len) - 1), stream[p]});
                crc = crc_tab(crc, stream[p]);
                p++;
            end
            if (p + 4 > stream.size()) return;
            rc = {stream[p], stream[p+1], stream[p+2], stream[p+3]};
            p += 4;
            crc = ~crc;
            exp_done.push_back({(rc != crc), 1'b0, crc});
        end
    endtask

    task automatic compare(input string name);
        chk({name, "_npay"}, 64'(act_pay.size()), 64'(exp_pay.size()));
        for (int i = 0; i < exp_pay.size() && i < act_pay.size(); i++)
            chk({name, "_pay"}, 64'(act_pay[i]), 64'(exp_pay[i]));
        chk({name, "_nhdr"}, 64'(act_hdr.size()), 64'(exp_hdr.size()));
        for (int i = 0; i < exp_hdr.size() && i < act_hdr.size(); i++)
            chk({name, "_hdr"}, act_hdr[i], exp_hdr[i]);
        chk({name, "_ndone"}, 64'(act_done.size()), 64'(exp_done.size()));
        for (int i = 0; i < exp_done.size() && i < act_done.size(); i++) begin
            if (exp_done[i][32])
                chk({name, "_lenerr"}, 64'(act_done[i][33:32]), 64'(exp_done[i][33:32]));
            else
                chk({name, "_done"}, 64'(act_done[i]), 64'(exp_done[i]));
        end
        act_pay.delete(); exp_pay.delete();
        act_hdr.delete(); exp_hdr.delete();
        act_done.delete(); exp_done.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        val_i = 1'b1;
        dat_i = b;
        @(negedge clk);
        val_i = 1'b0;
        dat_i = 8'($urandom);
    endtask

    task automatic drive(input bit gaps);
        foreach (stream[i]) send(stream[i], gaps);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic flush();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] c, ln, rc;
        int base;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? (32'hEDB8_8320 ^ (c >> 1)) : (c >> 1);
            tbl[n] = c;
        end

        rst = 1'b1; start_i = 1'b0; val_i = 1'b0; dat_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pulses", 64'({val_o, lst_o, hdr_val_o, done_o, err_o, len_err_o}), 64'h0);
        chk("rst_dat", 64'(dat_o), 64'h0);
        chk("rst_lentyp", {len_o, typ_o}, 64'h0);
        chk("rst_crc", 64'(crc_o), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        act_pay.delete(); act_hdr.delete(); act_done.delete();

        // IEND chunk, good CRC
        stream.delete(); add_iend(32'hAE42_6082);
        pulse_start(); drive(1'b0); flush(); model(); compare("iend");

        // IEND chunk, corrupted last CRC byte
        stream.delete(); add_iend(32'hAE42_6083);
        pulse_start(); drive(1'b0); flush(); model(); compare("iend_bad");
        chk("bad_err_hold", 64'({err_o, crc_o}), {31'h0, 1'b1, 32'hAE42_6082});

        // Five-byte payload with random gaps
        stream.delete(); add(32'h5); add(32'h3132_3334);
        for (int i = 0; i < 5; i++) stream.push_back(8'(8'h35 + i));
        add(32'hCBF4_3926);
        pulse_start(); drive(1'b1); flush(); model(); compare("pay5");

        // Oversized length, then bytes that must be ignored in IDLE
        stream.delete(); add(32'h8000_0000); add_iend(32'hAE42_6082);
        pulse_start(); drive(1'b1); flush(); model(); compare("lenerr");
        chk("lenerr_hold", 64'({err_o, len_err_o}), 64'h1);

        // Two IEND chunks back to back under one start
        stream.delete(); add_iend(32'hAE42_6082); add_iend(32'hAE42_6082);
        pulse_start(); drive(1'b1); flush(); model(); compare("b2b");

        // Reset during the third payload byte, then a clean IEND
        stream.delete(); add(32'h5); add(32'h3132_3334);
        stream.push_back(8'h35); stream.push_back(8'h36);
        pulse_start(); drive(1'b0); model();
        rst = 1'b1; val_i = 1'b1; dat_i = 8'h37;
        @(negedge clk);
        rst = 1'b0; val_i = 1'b0;
        chk("midrst_regs", {len_o, crc_o}, 64'h0);
        stream.delete(); add_iend(32'hAE42_6082);
        pulse_start(); drive(1'b1); flush(); model(); compare("midrst");

        // Abort with start_i during the third payload byte, then IEND
        stream.delete(); add(32'h5); add(32'h3132_3334);
        stream.push_back(8'h35); stream.push_back(8'h36);
        pulse_start(); drive(1'b0); model();
        start_i = 1'b1; val_i = 1'b1; dat_i = 8'h37;
        @(negedge clk);
        start_i = 1'b0; val_i = 1'b0;
        stream.delete(); add_iend(32'hAE42_6082);
        drive(1'b1); flush(); model(); compare("abort");

        // Random chunk pairs, some with a flipped CRC bit
        for (int r = 0; r < 6; r++) begin
            stream.delete();
            for (int ch = 0; ch < 2; ch++) begin
                ln = 32'($urandom_range(0, 12));
                add(ln);
                base = stream.size();
                add($urandom);
                for (int i = 0; i < int'(ln); i++) stream.push_back(8'($urandom));
                rc = 32'hFFFF_FFFF;
                for (int i = base; i < stream.size(); i++) rc = crc_tab(rc, stream[i]);
                rc = ~rc;
                if ($urandom_range(0, 1) == 1) rc = rc ^ (32'h1 << $urandom_range(0, 31));
                add(rc);
            end
            pulse_start(); drive(1'b1); flush(); model(); compare("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
